rx_edge_bit_sampler: RTL and testbench

UART RX front-end stage that sits directly upstream of the RX deserializer. It synchronizes the raw serial line and runs the oversampling edge counter and the bit counter. It takes a majority-vote sample around each bit centre. It supplies sampled_bit and edge_cnt to the deserializer, and bit_cnt to the RX FSM.

---
 rtl/rx_edge_bit_sampler.sv | 103 ++++++++++
 tb/tb_rx_edge_bit_sampler.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/rx_edge_bit_sampler.sv
// UART RX front end: line synchronizer, oversampling edge/bit counters and
// a three-point majority vote around each bit centre.
module rx_edge_bit_sampler #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned BIT_CNT_W   = 4
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 RX_IN,
   input  logic                 cnt_en,
   input  logic [5:0]           Prescale,
   output logic [4:0]           edge_cnt,
   output logic [BIT_CNT_W-1:0] bit_cnt,
   output logic                 sampled_bit,
   output logic                 sample_valid,
   output logic                 cfg_err
);

   localparam int unsigned SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
   localparam int unsigned PS_W   = 6;
   localparam int unsigned EC_W   = 5;

   logic [SYNC_N-1:0]    sync_q;
   logic                 en_q;
   logic [PS_W-1:0]      ps_q;
   logic [2:0]           vote_q;

   logic                 rx_s;
   logic                 en_rise;
   logic                 ps_legal;
   logic [PS_W-1:0]      ps_cap;
   logic [PS_W-1:0]      p_eff;
   logic [PS_W-1:0]      mid;
   logic [PS_W-1:0]      pos;
   logic [EC_W-1:0]      edge_d;
   logic [BIT_CNT_W-1:0] bit_d;
   logic [2:0]           vote_d;
   logic                 sb_d;
   logic                 sv_d;

   assign rx_s = sync_q[SYNC_N-1];

   // Next-state for counters and voter; the capture edge already uses the new ratio.
   always_comb begin
      en_rise  = cnt_en & ~en_q;
      ps_legal = (Prescale == 6'd8) || (Prescale == 6'd16) || (Prescale == 6'd32);
      ps_cap   = ps_legal ? Prescale : 6'd8;
      p_eff    = en_rise ? ps_cap : ps_q;
      mid      = p_eff >> 1;
      pos      = PS_W'(edge_cnt);

      edge_d   = '0;
      bit_d    = '0;
      vote_d   = vote_q;
      sb_d     = sampled_bit;
      sv_d     = 1'b0;

      if (cnt_en) begin
         if (pos == p_eff - 6'd1) begin
            edge_d = '0;
            bit_d  = bit_cnt + BIT_CNT_W'(1);
         end else begin
            edge_d = edge_cnt + EC_W'(1);
            bit_d  = bit_cnt;
         end
         if (pos == mid - 6'd2) vote_d[0] = rx_s;
         if (pos == mid - 6'd1) vote_d[1] = rx_s;
         if (pos == mid)        vote_d[2] = rx_s;
         if (pos == mid + 6'd1) begin
            sb_d = (vote_q[0] & vote_q[1]) | (vote_q[0] & vote_q[2]) |
                   (vote_q[1] & vote_q[2]);
            sv_d = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         sync_q       <= '1;
         en_q         <= 1'b0;
         ps_q         <= 6'd8;
         cfg_err      <= 1'b0;
         vote_q       <= '1;
         edge_cnt     <= '0;
         bit_cnt      <= '0;
         sampled_bit  <= 1'b1;
         sample_valid <= 1'b0;
      end else begin
         sync_q       <= {sync_q[SYNC_N-2:0], RX_IN};
         en_q         <= cnt_en;
         if (en_rise) begin
            ps_q    <= ps_cap;
            cfg_err <= ~ps_legal;
         end
         vote_q       <= vote_d;
         edge_cnt     <= edge_d;
         bit_cnt      <= bit_d;
         sampled_bit  <= sb_d;
         sample_valid <= sv_d;
      end
   end

endmodule

// File: tb/tb_rx_edge_bit_sampler.sv
// Randomized and directed bench for rx_edge_bit_sampler against a frame-position
// reference model.
module tb_rx_edge_bit_sampler;

   localparam int unsigned SYNC = 2;
   localparam int unsigned BW   = 4;

   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic          RX_IN = 1'b1;
   logic          cnt_en = 1'b0;
   logic [5:0]    Prescale = 6'd8;
   logic [4:0]    edge_cnt;
   logic [BW-1:0] bit_cnt;
   logic          sampled_bit;
   logic          sample_valid;
   logic          cfg_err;

   int total = 0;
   int bad   = 0;
   bit chk_on = 1'b1;
   int sv_cnt = 0;
   bit cap_q[$];

   rx_edge_bit_sampler #(.SYNC_STAGES(SYNC), .BIT_CNT_W(BW)) dut (
      .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .cnt_en(cnt_en), .Prescale(Prescale),
      .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .sampled_bit(sampled_bit),
      .sample_valid(sample_valid), .cfg_err(cfg_err)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string nm, input longint act, input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: frame position t since cnt_en rose, rx_s history of the frame.
   bit m_sync[$];
   bit m_en_prev = 1'b0;
   int m_p = 8;
   bit m_cfg = 1'b0;
   int m_t = 0;
   bit m_frame[$];
   int e_edge = 0;
   int e_bit = 0;
   bit e_sb = 1'b1;
   bit e_sv = 1'b0;

   always @(posedge CLK) begin
      bit rxs;
      int ones;
      if (!RST) begin
         m_sync = {};
         for (int i = 0; i < SYNC; i++) m_sync.push_back(1'b1);
         m_en_prev = 1'b0; m_p = 8; m_cfg = 1'b0; m_t = 0; m_frame = {};
         e_edge = 0; e_bit = 0; e_sb = 1'b1; e_sv = 1'b0;
      end else begin
         rxs = m_sync.pop_front();
         m_sync.push_back(RX_IN);
         e_sv = 1'b0;
         if (cnt_en) begin
            if (!m_en_prev) begin
               m_cfg = !(Prescale == 8 || Prescale == 16 || Prescale == 32);
               m_p   = m_cfg ? 8 : int'(Prescale);
               m_t   = 0;
               m_frame = {};
            end
            m_frame.push_back(rxs);
            if (m_t % m_p == m_p / 2 + 1) begin
               ones = int'(m_frame[m_t-3]) + int'(m_frame[m_t-2]) + int'(m_frame[m_t-1]);
               e_sb = (ones >= 2);
               e_sv = 1'b1;
            end
            m_t++;
            e_edge = m_t % m_p;
            e_bit  = (m_t / m_p) % (1 << BW);
         end else begin
            m_t = 0; e_edge = 0; e_bit = 0;
         end
         m_en_prev = cnt_en;
      end
   end

   always @(negedge CLK) begin
      if (chk_on) begin
         check("edge_cnt", edge_cnt, e_edge);
         check("bit_cnt", bit_cnt, e_bit);
         check("sampled_bit", sampled_bit, e_sb);
         check("sample_valid", sample_valid, e_sv);
         check("cfg_err", cfg_err, m_cfg);
         if (sample_valid) begin
            cap_q.push_back(sampled_bit);
            sv_cnt++;
         end
      end
   end

   task automatic cyc(input bit rst, input bit en, input bit [5:0] ps, input bit rx);
      @(negedge CLK);
      RST = rst; cnt_en = en; Prescale = ps; RX_IN = rx;
   endtask

   // One P=16 frame bit with rx_s = a,b,c at edges 6,7,8 and base elsewhere.
   task automatic vote_bit(input bit a, input bit b, input bit c, input bit base,
                           input bit exp, input string nm);
      bit w;
      for (int k = 0; k < 16; k++) begin
         w = (k + 2 == 6) ? a : (k + 2 == 7) ? b : (k + 2 == 8) ? c : base;
         cyc(1, 1, 6'd16, w);
      end
      cyc(1, 0, 6'd16, 1'b1);
      #1 check(nm, sampled_bit, exp);
   endtask

   initial begin
      bit bits [0:9];
      bit rx;
      int len, ps_sel, rst_at;
      bit [5:0] ps_tab [0:9];
      bit [7:0] byte_v;

      // Reset held with RX_IN toggling
      for (int i = 0; i < 3; i++) cyc(0, 1, 6'd16, 1'(i));
      cyc(1, 0, 6'd8, 1'b1);
      #1;
      check("rst_edge", edge_cnt, 0);
      check("rst_bit", bit_cnt, 0);
      check("rst_sb", sampled_bit, 1);
      check("rst_sv", sample_valid, 0);
      check("rst_cfg", cfg_err, 0);
      for (int i = 0; i < 3; i++) cyc(1, 0, 6'd8, 1'(i));
      #1;
      check("idle_edge", edge_cnt, 0);
      check("idle_sb", sampled_bit, 1);

      // P=8 counting for 80 cycles
      sv_cnt = 0;
      for (int i = 0; i < 80; i++) cyc(1, 1, 6'd8, 1'($urandom_range(0, 1)));
      cyc(1, 0, 6'd8, 1'b1);
      #1;
      check("p8_bit_cnt", bit_cnt, 10);
      check("p8_edge_cnt", edge_cnt, 0);
      check("p8_pulses", sv_cnt, 10);

      // Majority vote with P=16
      vote_bit(0, 0, 1, 0, 0, "vote_001");
      vote_bit(1, 0, 1, 0, 1, "vote_101");
      vote_bit(0, 1, 0, 0, 0, "vote_glitch");

      // 0xA5 8N1 frame at P=32
      byte_v = 8'hA5;
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[i+1] = byte_v[i];
      bits[9] = 1'b1;
      cap_q = {};
      for (int k = 0; k < 320; k++)
         cyc(1, 1, 6'd32, ((k + 2) / 32 < 10) ? bits[(k + 2) / 32] : 1'b1);
      cyc(1, 0, 6'd32, 1'b1);
      #1;
      check("a5_count", cap_q.size(), 10);
      if (cap_q.size() == 10) begin
         check("a5_b0", cap_q[0], 0); check("a5_b1", cap_q[1], 1);
         check("a5_b2", cap_q[2], 0); check("a5_b3", cap_q[3], 1);
         check("a5_b4", cap_q[4], 0); check("a5_b5", cap_q[5], 0);
         check("a5_b6", cap_q[6], 1); check("a5_b7", cap_q[7], 0);
         check("a5_b8", cap_q[8], 1); check("a5_b9", cap_q[9], 1);
      end

      // Illegal Prescale, then mid-frame change ignored
      for (int i = 0; i < 20; i++) cyc(1, 1, 6'd12, 1'b1);
      cyc(1, 1, 6'd16, 1'b1);
      #1 check("illegal_cfg", cfg_err, 1);
      check("illegal_wrap", edge_cnt, 20 % 8);
      for (int i = 0; i < 19; i++) cyc(1, 1, 6'd16, 1'b1);
      cyc(1, 0, 6'd16, 1'b1);
      #1 check("midchange_edge", edge_cnt, 40 % 8);
      cyc(1, 1, 6'd16, 1'b1);
      cyc(1, 1, 6'd16, 1'b1);
      #1 check("cfg_clear", cfg_err, 0);

      // Abort at edge 5 of bit 3, P=16
      cyc(1, 0, 6'd16, 1'b0);
      for (int i = 0; i < 53; i++) cyc(1, 1, 6'd16, (i < 44) ? 1'b0 : 1'b1);
      cyc(1, 0, 6'd16, 1'b1);
      #1;
      check("abort_pre_edge", edge_cnt, 5);
      check("abort_pre_bit", bit_cnt, 3);
      cyc(1, 0, 6'd16, 1'b1);
      #1;
      check("abort_edge", edge_cnt, 0);
      check("abort_bit", bit_cnt, 0);
      check("abort_sv", sample_valid, 0);
      check("abort_sb", sampled_bit, 0);

      // Random frames, illegal ratios, mid-frame ratio changes and resets
      ps_tab = '{6'd8, 6'd16, 6'd32, 6'd8, 6'd16, 6'd32, 6'd12, 6'd0, 6'd63, 6'd24};
      rx = 1'b1;
      for (int f = 0; f < 40; f++) begin
         ps_sel = $urandom_range(0, 9);
         len    = $urandom_range(5, 400);
         rst_at = ($urandom_range(0, 7) == 0) ? $urandom_range(0, len - 1) : -1;
         for (int k = 0; k < len; k++) begin
            if ($urandom_range(0, 7) == 0) rx = ~rx;
            if ($urandom_range(0, 63) == 0) ps_sel = $urandom_range(0, 9);
            cyc((k == rst_at) ? 1'b0 : 1'b1, 1'b1, ps_tab[ps_sel], rx);
         end
         for (int k = 0; k < $urandom_range(1, 4); k++) cyc(1, 0, ps_tab[ps_sel], rx);
      end
      cyc(1, 0, 6'd8, 1'b1);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
